// File: rtl/cache_fill_arbiter_if.sv
// Miss/fill bundle between the I/D caches, main memory and the fill arbiter.
// The arbiter side uses the slave modport; the cache/memory environment uses master.
interface cache_fill_arbiter_if #(
  parameter int BLOCK_WORDS = 8
);
  localparam int IW = $clog2(BLOCK_WORDS);

  logic          i_miss;
  logic [15:0]   i_miss_addr;
  logic          d_miss;
  logic [15:0]   d_miss_addr;
  logic          mem_en;
  logic [15:0]   mem_addr;
  logic          mem_valid;
  logic [15:0]   mem_data;
  logic          fill_we;
  logic          fill_sel;
  logic [IW-1:0] fill_idx;
  logic [15:0]   fill_data;
  logic          fill_done;
  logic          i_stall;
  logic          d_stall;

  modport slave (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_valid, mem_data,
    output mem_en, mem_addr, fill_we, fill_sel, fill_idx, fill_data, fill_done,
           i_stall, d_stall
  );

  modport master (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_valid, mem_data,
    input  mem_en, mem_addr, fill_we, fill_sel, fill_idx, fill_data, fill_done,
           i_stall, d_stall
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache misses (D first) and streams one block from memory into the owner's array.
// fill_done comes L+BLOCK_WORDS+1 cycles after capture; no backpressure, memory takes one read per cycle.
module cache_fill_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_fill_arbiter_if.slave  bus
);
  localparam int            IW       = $clog2(BLOCK_WORDS);
  localparam int            CW       = IW + 1;
  localparam logic [CW-1:0] LAST     = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST_M1  = CW'(BLOCK_WORDS - 1);
  localparam logic [15:0]   BASE_MSK = ~16'((1 << CW) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] issue_q, issue_d;
  logic [CW-1:0] recv_q,  recv_d;
  logic          owner_q, owner_d;
  logic [15:0]   base_q,  base_d;

  logic          mem_en_o;
  logic [15:0]   mem_addr_o;
  logic          fill_we_o;
  logic          fill_sel_o;
  logic [IW-1:0] fill_idx_o;
  logic [15:0]   fill_data_o;
  logic          fill_done_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      issue_q <= '0;
      recv_q  <= '0;
      owner_q <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      owner_q <= owner_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    recv_d      = recv_q;
    owner_d     = owner_q;
    base_d      = base_q;
    mem_en_o    = 1'b0;
    mem_addr_o  = '0;
    fill_we_o   = 1'b0;
    fill_sel_o  = 1'b0;
    fill_idx_o  = '0;
    fill_data_o = '0;
    fill_done_o = 1'b0;

    case (state_q)
      IDLE: begin
        // D wins a tie; a pending I miss is simply re-seen here after D's DONE.
        if (bus.d_miss) begin
          base_d  = bus.d_miss_addr & BASE_MSK;
          owner_d = 1'b1;
          issue_d = '0;
          recv_d  = '0;
          state_d = FILL;
        end else if (bus.i_miss) begin
          base_d  = bus.i_miss_addr & BASE_MSK;
          owner_d = 1'b0;
          issue_d = '0;
          recv_d  = '0;
          state_d = FILL;
        end
      end

      FILL: begin
        if (issue_q < LAST) begin
          mem_en_o   = 1'b1;
          mem_addr_o = base_q + {{(16 - CW - 1){1'b0}}, issue_q, 1'b0};
          issue_d    = issue_q + 1'b1;
        end
        if (bus.mem_valid && (recv_q < LAST)) begin
          fill_we_o   = 1'b1;
          fill_sel_o  = owner_q;
          fill_idx_o  = recv_q[IW-1:0];
          fill_data_o = bus.mem_data;
          recv_d      = recv_q + 1'b1;
          if (recv_q == LAST_M1) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        fill_done_o = 1'b1;
        fill_sel_o  = owner_q;
        issue_d     = '0;
        recv_d      = '0;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_en    = mem_en_o;
  assign bus.mem_addr  = mem_addr_o;
  assign bus.fill_we   = fill_we_o;
  assign bus.fill_sel  = fill_sel_o;
  assign bus.fill_idx  = fill_idx_o;
  assign bus.fill_data = fill_data_o;
  assign bus.fill_done = fill_done_o;

  // Owner stall stays up through DONE even if the cache already dropped its request.
  assign bus.i_stall = bus.i_miss | (!owner_q && (state_q != IDLE));
  assign bus.d_stall = bus.d_miss | ( owner_q && (state_q != IDLE));
endmodule
